usb_fifo_rx: RTL and testbench
==============================

# usb_fifo_rx

Receive front end for the USB 2.0 link. It reads bytes from an FT245-style parallel USB FIFO chip (RXF#/RD# handshake) and presents each byte as `d` with a one-cycle `d_accepted` strobe to the downstream frame decoder. It also marks frame boundaries with an inter-byte idle timeout, and reports frame length and buffer overflow. It sits between the board-level USB FIFO pins and the decoder's CRC/RAM stage.

## Interface
Parameters:
- `RD_PULSE`, default 3: clk cycles RD# is held low; data is sampled on the last of them (≥2).
- `RD_GAP`, default 3: clk cycles RD# is held high after each read before RXF# is re-examined (≥3, covers the 2-stage sync plus chip precharge).
- `IDLE_TIMEOUT`, default 255: idle clk cycles after the last byte before `frame_end` is declared (8-bit counter, 1..255).
- `MAX_LEN`, default 64: downstream buffer size in bytes.

Ports:
- `clk`, in, 1: system clock.
- `n_rst`, in, 1: asynchronous active-low reset.
- `rxf_n`, in, 1: FIFO "data available", active low, asynchronous to `clk`.
- `usb_d`, in, 8: FIFO data bus.
- `rd_n`, out, 1: FIFO read strobe, active low, registered.
- `d`, out, 8: received byte, held until the next byte.
- `d_accepted`, out, 1: one-cycle strobe; `d` is valid in that cycle.
- `frame_end`, out, 1: one-cycle pulse on timeout after ≥1 byte.
- `frame_len`, out, 6: bytes in the current or last frame, saturating at 63.
- `overflow`, out, 1: the frame exceeded `MAX_LEN`-1 bytes; cleared by the first byte of the next frame.

## Operation
- `rxf_n` passes through a 2-FF synchronizer to produce `rxf_s`. `usb_d` is sampled only while `rd_n` is low and is not synchronized.
- FSM states:
  - IDLE: if `rxf_s` = 0, go to RD_LOW and drive `rd_n` = 0.
  - RD_LOW: count `RD_PULSE` cycles. In the last one, register `usb_d` into `d`, then go to RD_HIGH.
  - RD_HIGH: `rd_n` = 1. `d_accepted` = 1 in the first cycle only. Count `RD_GAP` cycles, then go to IDLE.
- Frame tracking:
  - `in_frame` is set by `d_accepted`.
  - The idle counter clears on `d_accepted` and increments in IDLE while `in_frame` = 1.
  - When the counter reaches `IDLE_TIMEOUT`: pulse `frame_end`, clear `in_frame`.
  - On the first `d_accepted` of a frame (`in_frame` = 0): `frame_len` ← 1, `overflow` ← 0.
  - On each later byte: `frame_len` += 1, saturating at 63. `overflow` ← 1 if `frame_len` was already 63.
- Bytes are always forwarded, including during overflow; discarding them is the decoder's job.
- A new byte arriving in the same cycle the timeout would fire: the byte wins, the counter clears and `frame_end` does not pulse.

## Timing
- Reset values: `rd_n` = 1, `d` = 0, `d_accepted` = 0, `frame_end` = 0, `frame_len` = 0, `overflow` = 0, FSM = IDLE, sync FFs = 1, counters = 0.
- Latency from the `rxf_n` falling edge to `rd_n` low: 3 clk (2 sync + IDLE decision).
- Minimum byte period: 1 + `RD_PULSE` + `RD_GAP` clk (7 with defaults).
- `d_accepted` occurs 1 clk after the sampling edge; `d` is stable from that cycle until the next strobe.
- `frame_end` occurs `IDLE_TIMEOUT` + 1 clk after the last `d_accepted`.
- Reset mid-read: `rd_n` returns high asynchronously, the partial byte is dropped and no strobe is issued.
- `rxf_n` rising during RD_LOW is ignored; the read completes.

## Structure
- Package `usb_rx_pkg` holds:
  - the FSM state enum (IDLE, RD_LOW, RD_HIGH);
  - default constants `RD_PULSE_DEF`, `RD_GAP_DEF`, `IDLE_TIMEOUT_DEF`, `MAX_LEN_DEF`;
  - the `frame_len` width of 6.
- One sub-module: `sync2`, a generic 2-FF synchronizer with reset value 1, used for `rxf_n`.

## Test plan
- Reset, then one byte 0x5E (`rxf_n` low, then high after `rd_n` rises): `rd_n` low for 3 clk, exactly one `d_accepted` with `d` = 0x5E, `frame_len` = 1, `frame_end` 256 clk later.
- Back-to-back 13-byte frame 5E 4D 01 00 06 B4 01 02 03 04 05 06 2F (`rxf_n` held low): 13 strobes in order, 7 clk apart, `frame_len` = 13, single `frame_end`.
- 70 bytes with no gap: `frame_len` saturates at 63, `overflow` = 1 from the 64th byte; the next frame's first byte clears `overflow` and sets `frame_len` = 1.
- Inter-byte gap of `IDLE_TIMEOUT`-1 idle cycles, then 255 idle cycles: the first gap produces no `frame_end`; the second produces one pulse.
- `n_rst` asserted during RD_LOW: `rd_n` = 1 immediately, no `d_accepted`; after release the next byte is read normally.
- Glitch on `rxf_n` (low for 1 clk, not clock-aligned): either no read or one complete read occurs, and `rd_n` low-time is never shorter than `RD_PULSE`.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB FIFO receive front end.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_LOW  = 2'd1,
    RD_HIGH = 2'd2
  } rx_state_e;

  localparam int RD_PULSE_DEF     = 3;
  localparam int RD_GAP_DEF       = 3;
  localparam int IDLE_TIMEOUT_DEF = 255;
  localparam int MAX_LEN_DEF      = 64;

  localparam int FRAME_LEN_W   = 6;
  localparam int FRAME_LEN_MAX = (1 << FRAME_LEN_W) - 1;

  localparam logic [FRAME_LEN_W-1:0] FRAME_LEN_ONE = FRAME_LEN_W'(1);
  localparam logic [FRAME_LEN_W-1:0] FRAME_LEN_SAT = FRAME_LEN_W'(FRAME_LEN_MAX);

  function automatic logic [FRAME_LEN_W-1:0] sat_inc(input logic [FRAME_LEN_W-1:0] v);
    return (v == FRAME_LEN_SAT) ? v : v + FRAME_LEN_ONE;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer; resets to RST_VAL so an idle-high
// strobe does not look asserted while reset is released.
module sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        meta_q[gi] <= RST_VAL[gi];
        sync_q[gi] <= RST_VAL[gi];
      end else begin
        meta_q[gi] <= async_i[gi];
        sync_q[gi] <= meta_q[gi];
      end
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/usb_fifo_rx.sv
// FT245-style receive front end: RXF#/RD# read handshake, one-cycle byte
// strobe, and idle-timeout framing with length and overflow reporting.
module usb_fifo_rx
  import usb_rx_pkg::*;
#(
  parameter int RD_PULSE     = RD_PULSE_DEF,
  parameter int RD_GAP       = RD_GAP_DEF,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
  parameter int MAX_LEN      = MAX_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   rxf_n,
  input  logic [7:0]             usb_d,
  output logic                   rd_n,
  output logic [7:0]             d,
  output logic                   d_accepted,
  output logic                   frame_end,
  output logic [FRAME_LEN_W-1:0] frame_len,
  output logic                   overflow
);

  localparam logic [7:0] PULSE_LAST   = 8'(RD_PULSE - 1);
  localparam logic [7:0] GAP_LAST     = 8'(RD_GAP - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(IDLE_TIMEOUT - 1);

  // Overflow threshold clamps to the saturation point of frame_len.
  localparam int OVF_AT_INT = (MAX_LEN - 1 > FRAME_LEN_MAX) ? FRAME_LEN_MAX : MAX_LEN - 1;
  localparam logic [FRAME_LEN_W-1:0] OVF_AT = FRAME_LEN_W'(OVF_AT_INT);

  logic rxf_s;

  rx_state_e state_q, state_d;
  logic [7:0] ph_cnt_q, ph_cnt_d;
  logic       rd_n_q, rd_n_d;
  logic [7:0] d_q, d_d;
  logic       d_acc_q, d_acc_d;

  logic                   in_frame_q, in_frame_d;
  logic [7:0]             idle_cnt_q, idle_cnt_d;
  logic                   frame_end_q, frame_end_d;
  logic [FRAME_LEN_W-1:0] frame_len_q, frame_len_d;
  logic                   overflow_q, overflow_d;

  sync2 #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_rxf_sync (
    .clk    (clk),
    .n_rst  (n_rst),
    .async_i(rxf_n),
    .sync_o (rxf_s)
  );

  // rd_n is registered from the next state so it is low exactly while in RD_LOW.
  always_comb begin
    state_d  = state_q;
    ph_cnt_d = ph_cnt_q;
    rd_n_d   = 1'b1;
    d_d      = d_q;
    d_acc_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxf_s) begin
          state_d  = RD_LOW;
          ph_cnt_d = '0;
          rd_n_d   = 1'b0;
        end
      end
      RD_LOW: begin
        if (ph_cnt_q == PULSE_LAST) begin
          d_d      = usb_d;
          d_acc_d  = 1'b1;
          state_d  = RD_HIGH;
          ph_cnt_d = '0;
        end else begin
          rd_n_d   = 1'b0;
          ph_cnt_d = ph_cnt_q + 8'd1;
        end
      end
      RD_HIGH: begin
        if (ph_cnt_q == GAP_LAST) begin
          state_d  = IDLE;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        ph_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      ph_cnt_q <= '0;
      rd_n_q   <= 1'b1;
      d_q      <= '0;
      d_acc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_cnt_q <= ph_cnt_d;
      rd_n_q   <= rd_n_d;
      d_q      <= d_d;
      d_acc_q  <= d_acc_d;
    end
  end

  // A strobe takes priority over a timeout landing in the same cycle.
  always_comb begin
    in_frame_d  = in_frame_q;
    idle_cnt_d  = idle_cnt_q;
    frame_end_d = 1'b0;
    frame_len_d = frame_len_q;
    overflow_d  = overflow_q;
    if (d_acc_q) begin
      in_frame_d = 1'b1;
      idle_cnt_d = '0;
      if (!in_frame_q) begin
        frame_len_d = FRAME_LEN_ONE;
        overflow_d  = 1'b0;
      end else begin
        frame_len_d = sat_inc(frame_len_q);
        if (frame_len_q >= OVF_AT) begin
          overflow_d = 1'b1;
        end
      end
    end else if (in_frame_q) begin
      if (idle_cnt_q == TIMEOUT_LAST) begin
        frame_end_d = 1'b1;
        in_frame_d  = 1'b0;
        idle_cnt_d  = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      in_frame_q  <= 1'b0;
      idle_cnt_q  <= '0;
      frame_end_q <= 1'b0;
      frame_len_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      in_frame_q  <= in_frame_d;
      idle_cnt_q  <= idle_cnt_d;
      frame_end_q <= frame_end_d;
      frame_len_q <= frame_len_d;
      overflow_q  <= overflow_d;
    end
  end

  assign rd_n       = rd_n_q;
  assign d          = d_q;
  assign d_accepted = d_acc_q;
  assign frame_end  = frame_end_q;
  assign frame_len  = frame_len_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_usb_fifo_rx.sv
// Directed bench for usb_fifo_rx: an FT245 chip model feeds a table of bytes
// with chosen strobe spacing; hand sequences cover reset mid-read and glitches.
module tb_usb_fifo_rx;
  import usb_rx_pkg::*;

  localparam int RD_PULSE     = 3;
  localparam int IDLE_TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       rxf_chip = 1'b1;
  logic       glitch_low = 1'b0;
  logic       rxf_n;
  logic [7:0] usb_d = 8'h00;
  logic       rd_n;
  logic [7:0] d;
  logic       d_accepted;
  logic       frame_end;
  logic [FRAME_LEN_W-1:0] frame_len;
  logic       overflow;

  assign rxf_n = rxf_chip & ~glitch_low;

  always #5 clk = ~clk;

  usb_fifo_rx #(
    .RD_PULSE    (RD_PULSE),
    .RD_GAP      (3),
    .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .MAX_LEN     (64)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rxf_n     (rxf_n),
    .usb_d     (usb_d),
    .rd_n      (rd_n),
    .d         (d),
    .d_accepted(d_accepted),
    .frame_end (frame_end),
    .frame_len (frame_len),
    .overflow  (overflow)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Chip model: RXF# low while bytes are queued, byte popped on RD# rising.
  logic [7:0] chip_q[$];
  logic       chip_rd_prev = 1'b1;
  int         rxf_fall_cyc = 0;
  always begin
    @(posedge clk);
    #2;
    if (!chip_rd_prev && rd_n && chip_q.size() > 0) chip_q.delete(0);
    chip_rd_prev = rd_n;
    if (chip_q.size() > 0) begin
      if (rxf_chip) rxf_fall_cyc = cyc;
      rxf_chip = 1'b0;
      usb_d    = chip_q[0];
    end else begin
      rxf_chip = 1'b1;
      usb_d    = 8'h00;
    end
  end

  int checks = 0;
  int errors = 0;
  int fe_count = 0, last_fe_cyc = 0;
  int strobe_count = 0, strobe_cyc = 0;
  logic [7:0] strobe_d = 8'h00;
  int rd_run = 0, rd_fall_cyc = 0;
  bit chk_runs = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (frame_end) begin
      fe_count++;
      last_fe_cyc = cyc;
    end
    if (d_accepted) begin
      strobe_count++;
      strobe_cyc = cyc;
      strobe_d   = d;
    end
    if (!rd_n) begin
      if (rd_run == 0) rd_fall_cyc = cyc;
      rd_run++;
    end else if (rd_run > 0) begin
      if (chk_runs) check("rd_n_low_time", rd_run, RD_PULSE);
      rd_run = 0;
    end
  endtask

  task automatic wait_strobe(input string name, output bit ok);
    int sc0;
    sc0 = strobe_count;
    ok  = 1'b0;
    for (int g = 0; g < 400; g++) begin
      tick();
      if (strobe_count != sc0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no d_accepted within 400 cycles (cyc %0d)", name, cyc);
    end
  endtask

  // period: required strobe spacing from the previous byte; 0 = queued back to back.
  typedef struct {
    logic [7:0] data;
    int         period;
    int         exp_len;
    logic       exp_ovf;
    int         exp_fe;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] frame13 [13] = '{8'h5E, 8'h4D, 8'h01, 8'h00, 8'h06, 8'hB4, 8'h01,
                               8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h2F};

  task automatic add_vec(input logic [7:0] data, input int period, input int exp_len,
                         input logic exp_ovf, input int exp_fe);
    vec_t v;
    v.data    = data;
    v.period  = period;
    v.exp_len = exp_len;
    v.exp_ovf = exp_ovf;
    v.exp_fe  = exp_fe;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish by time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  prev_cyc, old_prev, fe_snap, sc0;
    bit  ok;

    add_vec(8'h5E, 0, 1, 1'b0, 0);
    add_vec(frame13[0], 300, 1, 1'b0, 1);
    for (int k = 1; k < 13; k++) add_vec(frame13[k], 0, k + 1, 1'b0, 0);
    add_vec(8'h11, 300, 1, 1'b0, 1);
    add_vec(8'h22, 255, 2, 1'b0, 0);
    add_vec(8'h33, 254, 3, 1'b0, 0);
    add_vec(8'h44, 256, 1, 1'b0, 1);
    add_vec(8'h55, 257, 1, 1'b0, 1);
    add_vec(8'(37), 300, 1, 1'b0, 1);
    for (int n = 2; n <= 70; n++)
      add_vec(8'(n * 37), 0, (n > 63) ? 63 : n, (n >= 64), 0);
    add_vec(8'hC3, 300, 1, 1'b0, 1);

    n_rst = 1'b0;
    tick();
    tick();
    check("reset_rd_n", rd_n, 1);
    check("reset_d", d, 0);
    check("reset_d_accepted", d_accepted, 0);
    check("reset_frame_end", frame_end, 0);
    check("reset_frame_len", frame_len, 0);
    check("reset_overflow", overflow, 0);
    n_rst = 1'b1;
    tick();

    chk_runs = 1'b1;
    fe_snap  = fe_count;
    prev_cyc = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0) begin
        chip_q.push_back(vecs[i].data);
      end else if (vecs[i].period > 0) begin
        while (cyc < prev_cyc + vecs[i].period - 7) tick();
        check("overflow_held", overflow, vecs[i-1].exp_ovf);
        chip_q.push_back(vecs[i].data);
      end
      if (i + 1 < vecs.size() && vecs[i+1].period == 0) chip_q.push_back(vecs[i+1].data);
      wait_strobe("byte_strobe", ok);
      if (ok) begin
        check("d", strobe_d, vecs[i].data);
        if (i > 0)
          check("strobe_period", strobe_cyc - prev_cyc, (vecs[i].period == 0) ? 7 : vecs[i].period);
        if (i == 0 || vecs[i].period > 0)
          check("rxf_to_rd_latency", rd_fall_cyc - rxf_fall_cyc, 3);
        old_prev = prev_cyc;
        prev_cyc = strobe_cyc;
        tick();
        check("frame_len", frame_len, vecs[i].exp_len);
        check("overflow", overflow, vecs[i].exp_ovf);
        check("frame_end_count", fe_count - fe_snap, vecs[i].exp_fe);
        if (vecs[i].exp_fe > 0 && i > 0)
          check("frame_end_cycle", last_fe_cyc, old_prev + IDLE_TIMEOUT + 1);
        fe_snap = fe_count;
        $display("vec %0d: d=%02h cyc=%0d frame_len=%0d overflow=%0b", i, strobe_d, strobe_cyc,
                 frame_len, overflow);
      end
    end

    for (int g = 0; g < 300; g++) tick();
    check("final_frame_end_count", fe_count - fe_snap, 1);
    check("final_frame_end_cycle", last_fe_cyc, prev_cyc + IDLE_TIMEOUT + 1);
    $display("final frame_end at cyc %0d", last_fe_cyc);

    // Reset asserted in the middle of RD_LOW.
    chk_runs = 1'b0;
    sc0 = strobe_count;
    chip_q.push_back(8'hA5);
    for (int g = 0; g < 40; g++) begin
      tick();
      if (!rd_n) break;
    end
    check("rd_n_low_before_reset", rd_n, 0);
    tick();
    #2 n_rst = 1'b0;
    #1;
    check("rd_n_async_reset", rd_n, 1);
    check("d_accepted_in_reset", d_accepted, 0);
    check("d_in_reset", d, 0);
    check("frame_len_in_reset", frame_len, 0);
    tick();
    tick();
    n_rst = 1'b1;
    for (int g = 0; g < 10; g++) tick();
    check("no_strobe_after_reset", strobe_count - sc0, 0);
    $display("reset mid-read: strobes=%0d", strobe_count - sc0);
    chk_runs = 1'b1;
    chip_q.push_back(8'h3C);
    wait_strobe("post_reset_strobe", ok);
    if (ok) begin
      check("post_reset_d", strobe_d, 8'h3C);
      tick();
      check("post_reset_frame_len", frame_len, 1);
      check("post_reset_overflow", overflow, 0);
      $display("post-reset byte: d=%02h frame_len=%0d", strobe_d, frame_len);
    end

    // One-clock, off-edge glitch on rxf_n with nothing queued.
    tick();
    sc0 = strobe_count;
    #3 glitch_low = 1'b1;
    #10 glitch_low = 1'b0;
    for (int g = 0; g < 30; g++) tick();
    check("glitch_reads_at_most_one", int'((strobe_count - sc0) > 1), 0);
    $display("glitch: reads=%0d", strobe_count - sc0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
